// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment digit scanner.
package seg_pkg;

    typedef enum logic {
        PRIME,
        SCAN
    } state_e;

    localparam logic [3:0]  BCD_MAX        = 4'd9;
    localparam int unsigned NUM_DIGITS_DEF = 4;

endpackage

// File: rtl/scan_prescaler.sv
// Free-running 0..DIV-1 counter with synchronous clear and a terminal-count tick.
module scan_prescaler #(
    parameter int unsigned DIV = 1000
) (
    input  logic clk_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned   CW = $clog2(DIV);
    localparam logic [CW-1:0] TC = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == TC) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clr_i && (cnt_q == TC);

endmodule

// File: rtl/digit_scanner.sv
// Multiplexed BCD display scanner: shadow register, PRIME/SCAN FSM, registered outputs.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading-zero positions above 0.
module digit_scanner
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int unsigned SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    output logic [3:0]              digit,
    output logic                    update,
    output logic [NUM_DIGITS-1:0]   anode
);

    localparam int unsigned   W    = 4 * NUM_DIGITS;
    localparam int unsigned   IW   = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    function automatic logic blank_f(input logic [W-1:0] w,
                                     input logic [IW-1:0] i);
        logic b;
        b = (w[{i, 2'b00} +: 4] > BCD_MAX);
`ifdef LEADING_ZERO_BLANK_EN
        if (i != '0) begin
            b = b | ((w >> {i, 2'b00}) == '0);
        end
`endif
        return b;
    endfunction

    state_e                  state_q;
    logic [W-1:0]            shadow_q;
    logic [IW-1:0]           idx_q;
    logic [IW-1:0]           idx_d;
    logic [3:0]              digit_q;
    logic                    update_q;
    logic                    upd_d;
    logic                    blank_q;
    logic [NUM_DIGITS-1:0]   anode_q;
    logic [W-1:0]            src;
    logic                    tick;

    scan_prescaler #(
        .DIV (SCAN_DIV)
    ) u_prescaler (
        .clk_i  (clk),
        .clr_i  (rst || (state_q != SCAN)),
        .tick_o (tick)
    );

    // The priming update forwards a same-cycle load so the first digit is fresh.
    always_comb begin
        idx_d = idx_q;
        src   = shadow_q;
        upd_d = 1'b0;
        unique case (state_q)
            PRIME: begin
                idx_d = '0;
                upd_d = 1'b1;
                if (load) begin
                    src = value;
                end
            end
            SCAN: begin
                if (tick) begin
                    upd_d = 1'b1;
                    idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= PRIME;
            shadow_q <= '0;
            idx_q    <= '0;
            digit_q  <= '0;
            update_q <= 1'b0;
            blank_q  <= 1'b0;
            anode_q  <= '0;
        end else begin
            state_q  <= SCAN;
            update_q <= upd_d;
            idx_q    <= idx_d;
            if (load) begin
                shadow_q <= value;
            end
            if (upd_d) begin
                digit_q <= src[{idx_d, 2'b00} +: 4];
                blank_q <= blank_f(src, idx_d);
            end
            if (update_q) begin
                anode_q <= blank_q ? '0
                         : {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
            end
        end
    end

    assign digit  = digit_q;
    assign update = update_q;
    assign anode  = anode_q;

endmodule

// File: tb/tb_digit_scanner.sv
// Directed scoreboard bench for digit_scanner (NUM_DIGITS=4, SCAN_DIV=4).
module tb_digit_scanner;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] d;
        logic [3:0] a;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  digit;
    logic        update;
    logic [3:0]  anode;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_upd = 0;
    bit   have_prev = 1'b0;
    bit   pend = 1'b0;
    logic [3:0] pend_an = '0;
    logic [3:0] exp_digit = '0;

    digit_scanner #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .value  (value),
        .load   (load),
        .digit  (digit),
        .update (update),
        .anode  (anode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [3:0] d, input logic [3:0] a);
        exp_t e;
        e.d = d;
        e.a = a;
        exp_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (update === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_update", 32'(update), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("digit", 32'(digit), 32'(e.d));
                if (have_prev) begin
                    chk("update_gap", 32'(cyc - last_upd), 32'd4);
                end
                exp_digit = e.d;
                pend_an   = e.a;
                pend      = 1'b1;
            end
            have_prev = 1'b1;
            last_upd  = cyc;
        end else begin
            chk("digit_hold", 32'(digit), 32'(exp_digit));
            if (pend) begin
                chk("anode", 32'(anode), 32'(pend_an));
                pend = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        exp_digit = 4'h0;
        step();
        chk("reset_update", 32'(update), 32'd0);
        chk("reset_anode", 32'(anode), 32'd0);
        chk("reset_digit", 32'(digit), 32'd0);

        // Load in the priming cycle; PRIME update shows nibble 0.
        rst = 1'b0;
        load = 1'b1;
        value = 16'h4321;
        push(4'h1, 4'b0001);
        step();
        load = 1'b0;
        chk("prime_anode_dark", 32'(anode), 32'd0);
        push(4'h2, 4'b0010);
        push(4'h3, 4'b0100);
        push(4'h4, 4'b1000);
        push(4'h1, 4'b0001);
        run(16);

        // Load coincident with the advance into position 1.
        run(3);
        load = 1'b1;
        value = 16'h9876;
        push(4'h2, 4'b0010);
        step();
        load = 1'b0;
        push(4'h8, 4'b0100);
        push(4'h9, 4'b1000);
        push(4'h6, 4'b0001);
        run(11);

        // Out-of-range nibble forwarded but blanked.
        load = 1'b1;
        value = 16'h00A5;
        step();
        load = 1'b0;
        push(4'hA, 4'b0000);
        push(4'h0, LZB ? 4'b0000 : 4'b0100);
        push(4'h0, LZB ? 4'b0000 : 4'b1000);
        push(4'h5, 4'b0001);
        run(15);

        load = 1'b1;
        value = 16'h0050;
        step();
        load = 1'b0;
        push(4'h5, 4'b0010);
        push(4'h0, LZB ? 4'b0000 : 4'b0100);
        push(4'h0, LZB ? 4'b0000 : 4'b1000);
        push(4'h0, 4'b0001);
        run(15);

        load = 1'b1;
        value = 16'h0000;
        step();
        load = 1'b0;
        push(4'h0, LZB ? 4'b0000 : 4'b0010);
        push(4'h0, LZB ? 4'b0000 : 4'b0100);
        push(4'h0, LZB ? 4'b0000 : 4'b1000);
        push(4'h0, 4'b0001);
        run(15);

        // Mid-scan reset with a competing load that must lose.
        run(1);
        chk("queue_drained_pre_rst", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        load = 1'b1;
        value = 16'hFFFF;
        have_prev = 1'b0;
        pend = 1'b0;
        exp_digit = 4'h0;
        step();
        chk("rst_update", 32'(update), 32'd0);
        chk("rst_anode", 32'(anode), 32'd0);
        rst = 1'b0;
        load = 1'b0;
        push(4'h0, 4'b0001);
        push(4'h0, LZB ? 4'b0000 : 4'b0010);
        run(5);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/digit_scanner.md
DIGIT_SCANNER -- requirements
Module: digit_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed display positions (2..8).
REQ-002 Parameter SCAN_DIV, default 1000, clock cycles each position is displayed (>=2).
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port value  input  4*NUM_DIGITS  BCD word; nibble i is position i, position 0 least significant.
REQ-006 Port load  input  1  single-cycle strobe capturing value into the shadow register.
REQ-007 Port digit  output  4  BCD nibble fed to the seven-segment decoder.
REQ-008 Port update  output  1  one-cycle strobe telling the decoder to register digit.
REQ-009 Port anode  output  NUM_DIGITS  position enables, active-high, at most one bit set.

Function
REQ-010 The block SHALL hold a shadow register; load=1 SHALL copy value into it at that edge.
REQ-011 The state machine SHALL have two states: PRIME (entered on reset) and SCAN.
REQ-012 In PRIME, the block SHALL assert update for exactly one cycle with digit = shadow nibble 0, then go to SCAN.
REQ-013 In SCAN, a prescaler SHALL count 0..SCAN_DIV-1 and wrap; the count SHALL be 0 in the first SCAN cycle.
REQ-014 When the prescaler is at SCAN_DIV-1, index SHALL advance (NUM_DIGITS-1 wraps to 0), update SHALL pulse for one cycle and digit SHALL be the shadow nibble of the new index.
REQ-015 digit SHALL be registered and SHALL change only in update cycles; it holds its value otherwise.
REQ-016 anode SHALL be registered one cycle after each update, so it changes in the same cycle as the decoder's seg output.
REQ-017 After that update, anode SHALL be one-hot at the current index.
REQ-018 A nibble greater than 9 SHALL be forwarded on digit unchanged, but its anode bit SHALL be held 0 (blanked).
REQ-019 load and the advance event in the same cycle: the update SHALL use the pre-load shadow contents; the new value SHALL appear from the next advance.
REQ-020 load SHALL NOT restart the prescaler or change index.
REQ-021 update SHALL never be asserted on two consecutive cycles.

Reset
REQ-022 rst=1 SHALL clear the shadow register, index, prescaler and digit to 0, set update=0 and anode=0, and enter PRIME.
REQ-023 rst mid-scan SHALL abandon the current position immediately; the first post-reset update is the PRIME update.
REQ-024 rst SHALL dominate load in the same cycle.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN compiled in: anode for position i>0 SHALL be held 0 when nibble i and all higher nibbles are 0.
REQ-026 LEADING_ZERO_BLANK_EN compiled in: position 0 SHALL always be lit, unless REQ-018 blanks it.
REQ-027 LEADING_ZERO_BLANK_EN compiled in: update timing and digit values SHALL be unchanged.
REQ-028 Without LEADING_ZERO_BLANK_EN: zero nibbles SHALL be displayed normally; only REQ-018 blanking applies.

Structure
REQ-029 Shared package seg_pkg SHALL hold the state enum (PRIME, SCAN), the BCD_MAX constant (9) and the default NUM_DIGITS.
REQ-030 Sub-module scan_prescaler SHALL implement the SCAN_DIV counter, producing a one-cycle tick at terminal count, with a synchronous clear.
REQ-031 Widths SHALL be $clog2-derived; the prescaler SHALL be wide enough for SCAN_DIV-1 without overflow.

Verification (NUM_DIGITS=4, SCAN_DIV=4)
REQ-032 Reset, load 16'h4321, run -> PRIME update with digit=1.
REQ-033 Continuing REQ-032: updates every 4 cycles with digit 2,3,4,1,...; anode 0001,0010,0100,1000,0001, each one cycle after its update.
REQ-034 load 16'h9876 coincident with an advance -> that update shows the old nibble; the next advance shows the new nibble at its index.
REQ-035 value 16'h00A5 -> the position-1 nibble (A) is forwarded as digit=4'hA with anode=0000 while position 1 is active.
REQ-036 LEADING_ZERO_BLANK_EN, value 16'h0050 -> anode positions 3 and 2 dark, 1 and 0 lit; value 16'h0000 -> only position 0 lit.
REQ-037 rst pulse mid-scan -> next cycle update=0 and anode=0; the following cycle is the PRIME update with digit=0.
